conv_mac4_9: RTL and testbench

- Consumer stage directly downstream of the 9-tap weight store.
- Requests one 36-word weight vector from the store by driving its load line and captures the vector when the store's valid rises. The vector holds 4 output channels × 9 taps.
- Accumulates 3×3 window dot products over a stream of input-channel windows and emits 4 saturated output words per tile.
- Sits between the weight store / window generator and the feature-map writeback.

---
 rtl/conv_mac4_9_pkg.sv | 22 ++
 rtl/conv_mac4_9_dot9_mac.sv | 40 ++++
 rtl/conv_mac4_9.sv | 95 +++++++++
 tb/tb_conv_mac4_9.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/conv_mac4_9_pkg.sv
// conv_mac4_9_pkg: shared constants, FSM encoding and saturation bounds for the 4-channel 3x3 MAC
package conv_mac4_9_pkg;
  localparam int DATA_LEN_C = 16;
  localparam int NTAP = 9;
  localparam int NCH = 4;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WREQ  = 3'd1,
    S_WWAIT = 3'd2,
    S_ACC   = 3'd3,
    S_DRAIN = 3'd4,
    S_OUT   = 3'd5
  } state_t;
  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
  localparam longint SAT_MAX = sat_hi(DATA_LEN_C);
  localparam longint SAT_MIN = sat_lo(DATA_LEN_C);
endpackage

// File: rtl/conv_mac4_9_dot9_mac.sv
// conv_mac4_9_dot9_mac: one output channel, 9 registered products then adder tree into an accumulator
module conv_mac4_9_dot9_mac
  import conv_mac4_9_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_C,
  parameter int ACC_W = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic [NTAP*DATA_LEN-1:0]   w_i,
  input  logic [NTAP*DATA_LEN-1:0]   x_i,
  output logic signed [ACC_W-1:0]    acc_o
);
  logic signed [2*DATA_LEN-1:0] p_q [NTAP];
  logic signed [2*DATA_LEN-1:0] p_d [NTAP];
  logic v_q;
  logic signed [ACC_W-1:0] sum, acc_q, acc_d;
  always_comb begin
    sum = '0;
    for (int i = 0; i < NTAP; i++) begin
      p_d[i] = $signed(w_i[i*DATA_LEN +: DATA_LEN]) * $signed(x_i[i*DATA_LEN +: DATA_LEN]);
      sum = sum + ACC_W'(p_q[i]);
    end
    acc_d = clr_i ? '0 : v_q ? acc_q + sum : acc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '{default: '0};
      v_q   <= 1'b0;
      acc_q <= '0;
    end else begin
      p_q   <= p_d;
      v_q   <= en_i;
      acc_q <= acc_d;
    end
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/conv_mac4_9.sv
// conv_mac4_9: weight-load, 3x3 MAC over 4 channels, shift/saturate output; CONV_MAC_RELU_EN clamps negatives to 0
module conv_mac4_9
  import conv_mac4_9_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_C,
  parameter int FRAC = 8,
  parameter int ACC_W = 40
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          w_load,
  input  logic                          w_valid,
  input  logic [NCH*NTAP*DATA_LEN-1:0]  w_q,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NTAP*DATA_LEN-1:0]      in_win,
  input  logic                          in_last,
  output logic                          out_valid,
  output logic [NCH*DATA_LEN-1:0]       out_q,
  output logic                          busy
);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(DATA_LEN));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(DATA_LEN));
  state_t state_q, state_d;
  logic drn_q, drn_d;
  logic [NCH*NTAP*DATA_LEN-1:0] wreg_q, wreg_d;
  logic [NCH*DATA_LEN-1:0] res_q, res_d, res_w;
  logic ov_q, ov_d;
  logic clr, acc_en;
  always_comb begin
    state_d = state_q;
    drn_d = 1'b0;
    wreg_d = wreg_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_WREQ : S_IDLE;
      S_WREQ:  state_d = S_WWAIT;
      S_WWAIT: begin
        state_d = w_valid ? S_ACC : S_WWAIT;
        wreg_d = w_valid ? w_q : wreg_q;
      end
      S_ACC:   state_d = (in_valid && in_last) ? S_DRAIN : S_ACC;
      S_DRAIN: begin
        drn_d = ~drn_q;
        state_d = drn_q ? S_OUT : S_DRAIN;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ov_d = state_q == S_OUT;
    res_d = ov_d ? res_w : res_q;
  end
  assign w_load = state_q == S_WREQ || state_q == S_WWAIT;
  assign in_ready = state_q == S_ACC;
  assign busy = state_q != S_IDLE;
  assign clr = state_q == S_IDLE && start;
  assign acc_en = in_ready && in_valid;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [ACC_W-1:0] acc, sh;
    logic signed [DATA_LEN-1:0] sat;
    conv_mac4_9_dot9_mac #(.DATA_LEN(DATA_LEN), .ACC_W(ACC_W)) u_dot9_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .en_i  (acc_en),
      .w_i   (wreg_q[c*NTAP*DATA_LEN +: NTAP*DATA_LEN]),
      .x_i   (in_win),
      .acc_o (acc)
    );
    assign sh = acc >>> FRAC;
    assign sat = (sh > HI) ? HI[DATA_LEN-1:0] : (sh < LO) ? LO[DATA_LEN-1:0] : sh[DATA_LEN-1:0];
`ifdef CONV_MAC_RELU_EN
    assign res_w[c*DATA_LEN +: DATA_LEN] = sat[DATA_LEN-1] ? '0 : sat;
`else
    assign res_w[c*DATA_LEN +: DATA_LEN] = sat;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      drn_q   <= 1'b0;
      wreg_q  <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drn_q   <= drn_d;
      wreg_q  <= wreg_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
    end
  end
  assign out_valid = ov_q;
  assign out_q = res_q;
endmodule

// File: tb/tb_conv_mac4_9.sv
// tb_conv_mac4_9: randomized and directed tiles checked against a plain-arithmetic convolution model
`timescale 1ns/1ps
module tb_conv_mac4_9;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic w_valid = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic w_load, in_ready, out_valid, busy;
  logic [575:0] w_q = '0;
  logic [143:0] in_win = '0;
  logic [63:0] out_q;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] wv [36];
  logic [143:0] wins [$];
`ifdef CONV_MAC_RELU_EN
  localparam logic [15:0] NEG_SAT = 16'h0000;
`else
  localparam logic [15:0] NEG_SAT = 16'h8000;
`endif
  always #5 clk = ~clk;
  conv_mac4_9 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_load(w_load), .w_valid(w_valid), .w_q(w_q),
    .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win), .in_last(in_last),
    .out_valid(out_valid), .out_q(out_q), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [143:0] rnd144();
    logic [143:0] v;
    for (int t = 0; t < 9; t++) v[t*16 +: 16] = 16'($urandom);
    return v;
  endfunction
  function automatic logic [575:0] rnd576();
    logic [575:0] v;
    for (int i = 0; i < 36; i++) v[i*16 +: 16] = 16'($urandom);
    return v;
  endfunction
  function automatic logic [15:0] expect_ch(input int c);
    longint a;
    a = 0;
    foreach (wins[k])
      for (int t = 0; t < 9; t++)
        a += longint'($signed(wv[c*9+t])) * longint'($signed(wins[k][t*16 +: 16]));
    a = a >>> 8;
    if (a > 32767) a = 32767;
    else if (a < -32768) a = -32768;
`ifdef CONV_MAC_RELU_EN
    if (a < 0) a = 0;
`endif
    return a[15:0];
  endfunction
  task automatic run_tile(input int gap_pct, input int wdly, input int abort_at);
    int n;
    start = 1'b1;
    in_valid = 1'b1;
    in_win = rnd144();
    w_valid = 1'b1;
    w_q = rnd576();
    tick;
    start = 1'b0;
    check("wreq_load", w_load, 1);
    check("wreq_busy", busy, 1);
    check("wreq_ready", in_ready, 0);
    tick;
    w_valid = 1'b0;
    for (int i = 0; i < wdly; i++) begin
      start = (i == 1);
      check("wwait_load", w_load, 1);
      check("wwait_ready", in_ready, 0);
      tick;
    end
    start = 1'b0;
    w_valid = 1'b1;
    foreach (wv[i]) w_q[i*16 +: 16] = wv[i];
    tick;
    w_valid = 1'b0;
    w_q = rnd576();
    in_valid = 1'b0;
    check("cap_load", w_load, 0);
    check("acc_ready", in_ready, 1);
    foreach (wins[k]) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_last = 1'b1;
        in_win = rnd144();
        start = 1'b1;
        tick;
      end
      start = 1'b0;
      in_valid = 1'b1;
      in_win = wins[k];
      in_last = (k == wins.size() - 1);
      tick;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_load", w_load, 0);
        check("rst_ov", out_valid, 0);
        check("rst_outq", out_q, 0);
        in_valid = 1'b0;
        repeat (4) begin
          tick;
          check("rst_hold_ov", out_valid, 0);
        end
        rst_n = 1'b1;
        tick;
        return;
      end
    end
    in_valid = 1'b1;
    in_last = 1'b1;
    in_win = rnd144();
    n = 1;
    while (out_valid !== 1'b1 && n < 16) begin
      check("drain_ready", in_ready, 0);
      start = (n == 3);
      tick;
      n++;
    end
    start = 1'b0;
    check("latency", n, 4);
    check("out_busy", busy, 0);
    for (int c = 0; c < 4; c++) check($sformatf("out_ch%0d", c), out_q[c*16 +: 16], expect_ch(c));
    in_valid = 1'b0;
    in_last = 1'b0;
    tick;
    check("ov_pulse", out_valid, 0);
    check("idle", busy, 0);
    check("hold", out_q[15:0], expect_ch(0));
  endtask
  task automatic rand_tile(input int nwin);
    foreach (wv[i]) wv[i] = 16'($urandom);
    wins.delete();
    for (int k = 0; k < nwin; k++) wins.push_back(rnd144());
  endtask
  initial begin
    logic [143:0] v;
    repeat (2) tick;
    check("reset_busy", busy, 0);
    check("reset_load", w_load, 0);
    check("reset_ready", in_ready, 0);
    check("reset_ov", out_valid, 0);
    check("reset_outq", out_q, 0);
    rst_n = 1'b1;
    tick;
    foreach (wv[i]) wv[i] = 16'h0100;
    for (int t = 0; t < 9; t++) v[t*16 +: 16] = 16'(16'h0100 * (t + 1));
    wins.delete();
    wins.push_back(v);
    run_tile(0, 4, -1);
    for (int c = 0; c < 4; c++) check("single_45", out_q[c*16 +: 16], 16'h2D00);
    for (int c = 0; c < 4; c++) for (int t = 0; t < 9; t++) wv[c*9+t] = 16'(16'h0100 * (c + 1));
    for (int t = 0; t < 9; t++) v[t*16 +: 16] = 16'h0100;
    wins.delete();
    repeat (3) wins.push_back(v);
    run_tile(0, 2, -1);
    check("mc_ch0", out_q[15:0], 16'h1B00);
    check("mc_ch1", out_q[31:16], 16'h3600);
    check("mc_ch2", out_q[47:32], 16'h5100);
    check("mc_ch3", out_q[63:48], 16'h6C00);
    foreach (wv[i]) wv[i] = 16'h7FFF;
    for (int t = 0; t < 9; t++) v[t*16 +: 16] = 16'h7FFF;
    wins.delete();
    repeat (16) wins.push_back(v);
    run_tile(0, 3, -1);
    for (int c = 0; c < 4; c++) check("sat_pos", out_q[c*16 +: 16], 16'h7FFF);
    foreach (wv[i]) wv[i] = 16'h8000;
    run_tile(20, 3, -1);
    for (int c = 0; c < 4; c++) check("sat_neg", out_q[c*16 +: 16], NEG_SAT);
    rand_tile(5);
    run_tile(0, 2, 1);
    rand_tile(3);
    run_tile(0, 2, -1);
    for (int r = 0; r < 8; r++) begin
      rand_tile(1 + $urandom_range(5));
      run_tile(40, 1 + $urandom_range(5), -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
